// File: rtl/sme_driver_pkg.sv
// sme_driver_pkg: FSM encoding and buffer-depth defaults shared by the driver and the matcher.
package sme_driver_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SEND_STR, S_GAP, S_SEND_PAT, S_WAIT_VALID, S_DONE
  } state_t;
  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sme_char_buf.sv
// sme_char_buf: depth x 8 char buffer with length counter, clear, drop-on-full flag and indexed read.
module sme_char_buf #(
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic          i_clr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_idx,
  output logic [7:0]    o_rd_data,
  output logic [LW-1:0] o_len,
  output logic          o_drop
);
  logic [7:0]    r_mem [DEPTH];
  logic [LW-1:0] r_len;
  logic          w_full;
  logic          w_wr;
  assign w_full    = r_len == LW'(DEPTH);
  assign w_wr      = i_wr_en && !i_clr && !w_full;
  assign o_drop    = i_wr_en && !i_clr && w_full;
  assign o_rd_data = r_mem[i_rd_idx];
  assign o_len     = r_len;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_len <= '0;
    else if (i_clr) r_len <= '0;
    else if (w_wr) r_len <= r_len + 1'b1;
  // Contents are left unreset; only the length defines what is valid.
  always_ff @(posedge i_clk)
    if (w_wr) r_mem[r_len[AW-1:0]] <= i_wr_data;
endmodule

// File: rtl/sme_driver.sv
// sme_driver: buffers a string and a pattern, frames them onto the matcher's char interface
// and captures the matcher's result (or a timeout).
module sme_driver
  import sme_driver_pkg::*;
#(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int GAP     = 1,
  parameter int TMO     = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_en,
  input  logic       i_wr_sel,
  input  logic [7:0] i_wr_data,
  input  logic       i_wr_clr,
  input  logic       i_start,
  input  logic       i_send_str,
  output logic [7:0] o_chardata,
  output logic       o_isstring,
  output logic       o_ispattern,
  input  logic       i_valid,
  input  logic       i_match,
  input  logic [4:0] i_match_index,
  output logic       o_busy,
  output logic       o_res_valid,
  output logic       o_res_match,
  output logic [4:0] o_res_index,
  output logic       o_res_timeout,
  output logic       o_ovf
);
  localparam int SLW = $clog2(STR_MAX + 1);
  localparam int PLW = $clog2(PAT_MAX + 1);
  localparam int SAW = $clog2(STR_MAX);
  localparam int PAW = $clog2(PAT_MAX);
  localparam int IW  = max2(SLW, max2(PLW, $clog2(GAP + 1)));
  localparam int TW  = $clog2(TMO + 1);
  state_t          r_state, w_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [TW-1:0]   r_tmo;
  logic [SLW-1:0]  w_str_len;
  logic [PLW-1:0]  w_pat_len;
  logic [7:0]      w_str_rd, w_pat_rd;
  logic            w_accept, w_load, w_str_drop, w_pat_drop;
  logic            w_str_last, w_gap_last, w_pat_last, w_tmo_hit;
  logic [7:0]      r_chardata;
  logic            r_isstring, r_ispattern, r_busy, r_res_valid, r_res_match, r_res_timeout, r_ovf;
  logic [4:0]      r_res_index;
  assign w_accept   = i_start && r_state == S_IDLE && w_pat_len != '0 && (!i_send_str || w_str_len != '0);
  assign w_load     = r_state == S_IDLE && !w_accept;
  assign w_str_last = (r_idx + 1'b1) == IW'(w_str_len);
  assign w_pat_last = (r_idx + 1'b1) == IW'(w_pat_len);
  assign w_gap_last = r_idx == IW'(GAP - 1);
  assign w_tmo_hit  = r_tmo == TW'(TMO);
  sme_char_buf #(.DEPTH(STR_MAX)) u_str (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wr_en(w_load && i_wr_en && !i_wr_sel), .i_clr(w_load && i_wr_clr && !i_wr_sel),
    .i_wr_data(i_wr_data), .i_rd_idx(w_idx_nxt[SAW-1:0]),
    .o_rd_data(w_str_rd), .o_len(w_str_len), .o_drop(w_str_drop)
  );
  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wr_en(w_load && i_wr_en && i_wr_sel), .i_clr(w_load && i_wr_clr && i_wr_sel),
    .i_wr_data(i_wr_data), .i_rd_idx(w_idx_nxt[PAW-1:0]),
    .o_rd_data(w_pat_rd), .o_len(w_pat_len), .o_drop(w_pat_drop)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_nxt;
      r_idx   <= w_idx_nxt;
      r_tmo   <= r_state != S_WAIT_VALID ? '0 : w_tmo_hit ? r_tmo : r_tmo + 1'b1;
    end
  always_comb begin
    w_nxt     = r_state;
    w_idx_nxt = r_idx;
    case (r_state)
      S_IDLE: begin
        w_nxt     = !w_accept ? S_IDLE : i_send_str ? S_SEND_STR : S_SEND_PAT;
        w_idx_nxt = '0;
      end
      S_SEND_STR: begin
        w_nxt     = w_str_last ? S_GAP : S_SEND_STR;
        w_idx_nxt = w_str_last ? '0 : r_idx + 1'b1;
      end
      S_GAP: begin
        w_nxt     = w_gap_last ? S_SEND_PAT : S_GAP;
        w_idx_nxt = w_gap_last ? '0 : r_idx + 1'b1;
      end
      S_SEND_PAT: begin
        w_nxt     = w_pat_last ? S_WAIT_VALID : S_SEND_PAT;
        w_idx_nxt = w_pat_last ? '0 : r_idx + 1'b1;
      end
      S_WAIT_VALID: w_nxt = (i_valid || w_tmo_hit) ? S_DONE : S_WAIT_VALID;
      default:      w_nxt = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state so framing lines up with the state it describes.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_chardata    <= '0;
      r_isstring    <= 1'b0;
      r_ispattern   <= 1'b0;
      r_busy        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_match   <= 1'b0;
      r_res_index   <= '0;
      r_res_timeout <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      r_isstring  <= w_nxt == S_SEND_STR;
      r_ispattern <= w_nxt == S_SEND_PAT;
      r_chardata  <= w_nxt == S_SEND_STR ? w_str_rd : w_nxt == S_SEND_PAT ? w_pat_rd : '0;
      r_busy      <= w_nxt != S_IDLE && w_nxt != S_DONE;
      r_res_valid <= w_nxt == S_DONE;
      r_ovf       <= (w_load && i_wr_clr) ? 1'b0 : (w_str_drop || w_pat_drop) ? 1'b1 : r_ovf;
      if (r_state == S_WAIT_VALID && w_nxt == S_DONE) begin
        r_res_match   <= i_valid && i_match;
        r_res_index   <= i_valid ? i_match_index : '0;
        r_res_timeout <= !i_valid;
      end
    end
  assign o_chardata    = r_chardata;
  assign o_isstring    = r_isstring;
  assign o_ispattern   = r_ispattern;
  assign o_busy        = r_busy;
  assign o_res_valid   = r_res_valid;
  assign o_res_match   = r_res_match;
  assign o_res_index   = r_res_index;
  assign o_res_timeout = r_res_timeout;
  assign o_ovf         = r_ovf;
endmodule

// File: tb/tb_sme_driver.sv
// tb_sme_driver: random loads and transactions checked against a queue-based model of the driver.
module tb_sme_driver;
  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int GAP     = 1;
  localparam int TMO     = 10;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, wr_sel = 1'b0, wr_clr = 1'b0, start = 1'b0, send_str = 1'b0;
  logic [7:0] wr_data = '0;
  logic       valid = 1'b0, match = 1'b0;
  logic [4:0] match_index = '0;
  logic [7:0] chardata;
  logic       isstring, ispattern, busy, res_valid, res_match, res_timeout, ovf;
  logic [4:0] res_index;
  always #5 clk = ~clk;
  sme_driver #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .GAP(GAP), .TMO(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_data(wr_data),
    .i_wr_clr(wr_clr), .i_start(start), .i_send_str(send_str), .o_chardata(chardata),
    .o_isstring(isstring), .o_ispattern(ispattern), .i_valid(valid), .i_match(match),
    .i_match_index(match_index), .o_busy(busy), .o_res_valid(res_valid), .o_res_match(res_match),
    .o_res_index(res_index), .o_res_timeout(res_timeout), .o_ovf(ovf)
  );
  int            n_tests = 0, n_fail = 0;
  byte unsigned  m_str[$], m_pat[$];
  bit            m_ovf = 0, m_rm = 0, m_rto = 0;
  logic [4:0]    m_ri = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_wr(input bit sel, input byte unsigned d);
    if (sel) begin
      if (m_pat.size() < PAT_MAX) m_pat.push_back(d); else m_ovf = 1;
    end else begin
      if (m_str.size() < STR_MAX) m_str.push_back(d); else m_ovf = 1;
    end
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, ".frame"}, {isstring, ispattern, chardata}, '0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".rvalid"}, res_valid, 0);
    chk({tag, ".res"}, {res_timeout, res_match, res_index}, {m_rto, m_rm, m_ri});
    chk({tag, ".ovf"}, ovf, m_ovf);
  endtask
  task automatic wr(input bit sel, input byte unsigned d);
    wr_en = 1; wr_sel = sel; wr_data = d;
    @(negedge clk);
    wr_en = 0;
    model_wr(sel, d);
  endtask
  task automatic clr(input bit sel);
    wr_clr = 1; wr_sel = sel;
    @(negedge clk);
    wr_clr = 0;
    if (sel) m_pat.delete(); else m_str.delete();
    m_ovf = 0;
  endtask
  task automatic load(input bit sel, input string s);
    clr(sel);
    for (int i = 0; i < s.len(); i++) wr(sel, s[i]);
  endtask
  // vdelay: WAIT_VALID cycle (0-based) on which valid is pulsed; >TMO means never.
  task automatic txn(input bit ss, input int vdelay, input bit mt, input logic [4:0] mi);
    logic [9:0]   q[$];
    bit           acc, wsel;
    byte unsigned wd;
    int           k;
    acc = m_pat.size() != 0 && (!ss || m_str.size() != 0);
    if (ss) begin
      foreach (m_str[i]) q.push_back({2'b10, m_str[i]});
      repeat (GAP) q.push_back(10'd0);
    end
    foreach (m_pat[i]) q.push_back({2'b01, m_pat[i]});
    wsel = 1'($urandom); wd = 8'($urandom);
    start = 1; send_str = ss; wr_en = 1; wr_sel = wsel; wr_data = wd;
    @(negedge clk);
    start = 0; wr_en = 0;
    if (!acc) begin
      model_wr(wsel, wd);
      chk("rej.busy", busy, 0);
      chk("rej.frame", {isstring, ispattern, chardata}, '0);
      return;
    end
    foreach (q[i]) begin
      chk($sformatf("frame%0d", i), {isstring, ispattern, chardata}, q[i]);
      chk($sformatf("busy%0d", i), busy, 1);
      valid = 1'($urandom); match = 1'($urandom); match_index = 5'($urandom);
      wr_en = 1'($urandom); wr_sel = 1'($urandom); wr_data = 8'($urandom);
      @(negedge clk);
    end
    valid = 0; wr_en = 0;
    for (k = 0; k <= TMO; k++) begin
      chk($sformatf("wait%0d", k), {busy, res_valid, isstring, ispattern, chardata}, {1'b1, 11'd0});
      if (k == vdelay) begin valid = 1; match = mt; match_index = mi; end
      @(negedge clk);
      valid = 0;
      if (k == vdelay) break;
    end
    if (vdelay >= 0 && vdelay <= TMO) begin m_rm = mt; m_ri = mi; m_rto = 0; end
    else begin m_rm = 0; m_ri = '0; m_rto = 1; end
    chk("done.rvalid", res_valid, 1);
    chk("done.busy", busy, 0);
    chk("done.res", {res_timeout, res_match, res_index}, {m_rto, m_rm, m_ri});
    chk("done.frame", {isstring, ispattern, chardata}, '0);
    @(negedge clk);
    idle_chk("post");
  endtask
  initial begin
    repeat (2) @(negedge clk);
    idle_chk("reset");
    rst_n = 1;
    @(negedge clk);
    load(0, "ab cd");
    load(1, "cd");
    txn(1, 3, 1, 5'd3);
    load(1, "^a");
    txn(0, 2, 0, 5'd7);
    txn(0, TMO + 5, 1, 5'd9);
    txn(1, TMO, 1, 5'd31);
    clr(1);
    for (int i = 0; i < 9; i++) wr(1, 8'(8'h41 + i));
    chk("ovf.set", ovf, 1);
    txn(0, 1, 1, 5'd4);
    clr(1);
    chk("ovf.clr", ovf, 0);
    txn(0, 0, 1, 5'd1);
    idle_chk("ignored");
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 3) == 0) clr(0);
      if ($urandom_range(0, 1) == 0) clr(1);
      repeat ($urandom_range(0, it == 7 ? STR_MAX + 2 : 5)) wr(0, 8'($urandom));
      repeat ($urandom_range(0, 4)) wr(1, 8'($urandom));
      chk("rnd.ovf", ovf, m_ovf);
      txn(1'($urandom), $urandom_range(0, TMO + 3), 1'($urandom), 5'($urandom));
    end
    load(0, "xyz");
    load(1, "y");
    start = 1; send_str = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("mid.isstr", isstring, 1);
    #2 rst_n = 0;
    #1;
    chk("rst.frame", {isstring, ispattern, chardata}, '0);
    chk("rst.busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    m_str.delete(); m_pat.delete();
    m_ovf = 0; m_rm = 0; m_ri = '0; m_rto = 0;
    @(negedge clk);
    idle_chk("rst.idle");
    txn(1, 0, 1, 5'd2);
    txn(0, 0, 1, 5'd2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
